// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// The optional SRAM_ARB_LOCK_EN build adds grant locking; nothing here changes with it.
package sram_arb_pkg;

  localparam int unsigned MAX_REQ  = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned BYTEEN_W = 4;

  typedef struct packed {
    logic       valid;
    logic [1:0] owner;
  } tag_t;

  // (base + off) mod n, for round-robin index walking.
  function automatic logic [1:0] rr_wrap(input logic [1:0] base, input int unsigned off,
                                         input int unsigned n);
    int unsigned sum;
    sum = 32'(base) + off;
    return 2'(sum % n);
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester, response and SRAM-side signals of the SRAM port arbiter.
// req_lock exists only when SRAM_ARB_LOCK_EN is defined.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned MEM_AWIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*MEM_AWIDTH-1:0] req_addr;
  logic [NUM_REQ*BYTEEN_W-1:0]   req_byteen;
  logic [NUM_REQ*DATA_W-1:0]     req_wdata;
`ifdef SRAM_ARB_LOCK_EN
  logic [NUM_REQ-1:0]            req_lock;
`endif
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_W-1:0]             rsp_rdata;
  logic                          mem_ren;
  logic                          mem_wen;
  logic [MEM_AWIDTH-1:0]         mem_addr;
  logic [BYTEEN_W-1:0]           mem_byteen;
  logic [DATA_W-1:0]             mem_wdata;
  logic [DATA_W-1:0]             mem_rdata;

  modport slave (
`ifdef SRAM_ARB_LOCK_EN
    input  req_lock,
`endif
    input  req_valid, req_write, req_addr, req_byteen, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, mem_ren, mem_wen, mem_addr, mem_byteen, mem_wdata
  );

  modport master (
`ifdef SRAM_ARB_LOCK_EN
    output req_lock,
`endif
    output req_valid, req_write, req_addr, req_byteen, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, mem_ren, mem_wen, mem_addr, mem_byteen, mem_wdata
  );

endinterface

// File: rtl/sram_arb_rr.sv
// Round-robin pointer and one-hot grant; a locked last winner keeps the grant.
// Lock is a plain input here; the top ties it low unless SRAM_ARB_LOCK_EN is defined.
module sram_arb_rr
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [NUM_REQ-1:0] lock_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [1:0]         gnt_idx_o,
  output logic               gnt_vld_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] last_q, last_d;
  logic       hold;
  logic [1:0] cand;

  always_comb begin
    hold      = 1'b0;
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand      = '0;
    ptr_d     = ptr_q;
    last_d    = last_q;

    for (int i = 0; i < NUM_REQ; i++) begin
      if (last_q == 2'(i)) hold = valid_i[i] & lock_i[i];
    end

    if (hold) begin
      gnt_idx_o = last_q;
      gnt_vld_o = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = rr_wrap(ptr_q, unsigned'(k), NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++) begin
          if (!gnt_vld_o && cand == 2'(i) && valid_i[i]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = cand;
          end
        end
      end
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld_o && gnt_idx_o == 2'(i)) gnt_o[i] = 1'b1;
    end

    // A locked re-grant leaves the pointer where it was.
    if (gnt_vld_o && !hold) begin
      ptr_d  = rr_wrap(gnt_idx_o, 1, NUM_REQ);
      last_d = gnt_idx_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr_q  <= '0;
      last_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM port between NUM_REQ requesters: registered issue stage plus read-tag pipe.
// Define SRAM_ARB_LOCK_EN to enable the req_lock grant-hold feature.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned MEM_AWIDTH = 16,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              HCLK,
  input  logic              HRESET,
  sram_port_arbiter_if.slave bus
);

  logic [NUM_REQ-1:0]    gnt;
  logic [1:0]            gnt_idx;
  logic                  gnt_vld;
  logic [NUM_REQ-1:0]    lock;

  logic                  sel_write;
  logic [MEM_AWIDTH-1:0] sel_addr;
  logic [BYTEEN_W-1:0]   sel_byteen;
  logic [DATA_W-1:0]     sel_wdata;

  logic                  mem_ren_q, mem_wen_q;
  logic [MEM_AWIDTH-1:0] mem_addr_q;
  logic [BYTEEN_W-1:0]   mem_byteen_q;
  logic [DATA_W-1:0]     mem_wdata_q;
  tag_t                  tag_q [RD_LATENCY+1];
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]     rsp_rdata_q;

`ifdef SRAM_ARB_LOCK_EN
  assign lock = bus.req_lock;
`else
  assign lock = '0;
`endif

  sram_arb_rr #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk_i    (HCLK),
    .rst_i    (HRESET),
    .valid_i  (bus.req_valid),
    .lock_i   (lock),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx),
    .gnt_vld_o(gnt_vld)
  );

  assign bus.req_ready = gnt;

  always_comb begin
    sel_write  = 1'b0;
    sel_addr   = '0;
    sel_byteen = '0;
    sel_wdata  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == 2'(i)) begin
        sel_write  = bus.req_write[i];
        sel_addr   = bus.req_addr[i*MEM_AWIDTH +: MEM_AWIDTH];
        sel_byteen = bus.req_byteen[i*BYTEEN_W +: BYTEEN_W];
        sel_wdata  = bus.req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Tag at the last stage lines up with the cycle mem_rdata is valid.
  always_comb begin
    rsp_valid_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (tag_q[RD_LATENCY].valid && tag_q[RD_LATENCY].owner == 2'(i)) rsp_valid_d[i] = 1'b1;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      mem_ren_q    <= 1'b0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_byteen_q <= '0;
      mem_wdata_q  <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) tag_q[i] <= '0;
      rsp_valid_q  <= '0;
      rsp_rdata_q  <= '0;
    end else begin
      mem_ren_q <= gnt_vld & ~sel_write;
      mem_wen_q <= gnt_vld & sel_write;
      if (gnt_vld) begin
        mem_addr_q   <= sel_addr;
        mem_byteen_q <= sel_byteen;
        mem_wdata_q  <= sel_wdata;
      end
      tag_q[0] <= '{valid: gnt_vld & ~sel_write, owner: gnt_idx};
      for (int i = 1; i <= RD_LATENCY; i++) tag_q[i] <= tag_q[i-1];
      rsp_valid_q <= rsp_valid_d;
      if (tag_q[RD_LATENCY].valid) rsp_rdata_q <= bus.mem_rdata;
    end
  end

  assign bus.mem_ren    = mem_ren_q;
  assign bus.mem_wen    = mem_wen_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_byteen = mem_byteen_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench: one arbiter with a 1-cycle SRAM model, one with a 2-cycle SRAM model.
// Lock scenario runs only when SRAM_ARB_LOCK_EN is defined.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned AW = 16;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  always #5 HCLK = ~HCLK;

  sram_port_arbiter_if #(.NUM_REQ(NR), .MEM_AWIDTH(AW)) a_if ();
  sram_port_arbiter_if #(.NUM_REQ(NR), .MEM_AWIDTH(AW)) b_if ();

  sram_port_arbiter #(.NUM_REQ(NR), .MEM_AWIDTH(AW), .RD_LATENCY(1)) u_dut_a (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (a_if)
  );

  sram_port_arbiter #(.NUM_REQ(NR), .MEM_AWIDTH(AW), .RD_LATENCY(2)) u_dut_b (
    .HCLK  (HCLK),
    .HRESET(HRESET),
    .bus   (b_if)
  );

  // SRAM models: preset contents, byte-enabled writes.
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] rd1, rd2a, rd2b;

  function automatic logic [31:0] init_word(input int i);
    if (i == 'h10) return 32'hDEADBEEF;
    if (i == 'h20) return 32'hAABBCCDD;
    return 32'h1111_0000 + 32'(i);
  endfunction

  always @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < 256; i++) mem1[i] <= init_word(i);
      rd1 <= '0;
    end else begin
      if (a_if.mem_wen)
        for (int b = 0; b < 4; b++)
          if (a_if.mem_byteen[b]) mem1[a_if.mem_addr[7:0]][b*8 +: 8] <= a_if.mem_wdata[b*8 +: 8];
      if (a_if.mem_ren) rd1 <= mem1[a_if.mem_addr[7:0]];
    end
  end

  always @(posedge HCLK) begin
    if (HRESET) begin
      for (int i = 0; i < 256; i++) mem2[i] <= init_word(i);
      rd2a <= '0;
      rd2b <= '0;
    end else begin
      if (b_if.mem_ren) rd2a <= mem2[b_if.mem_addr[7:0]];
      rd2b <= rd2a;
    end
  end

  assign a_if.mem_rdata = rd1;
  assign b_if.mem_rdata = rd2b;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive_a(input int i, input logic v, input logic wr, input logic [15:0] addr,
                         input logic [3:0] be, input logic [31:0] wd);
    a_if.req_valid[i]          = v;
    a_if.req_write[i]          = wr;
    a_if.req_addr[i*16 +: 16]  = addr;
    a_if.req_byteen[i*4 +: 4]  = be;
    a_if.req_wdata[i*32 +: 32] = wd;
  endtask

  task automatic drive_b(input int i, input logic v, input logic [15:0] addr);
    b_if.req_valid[i]          = v;
    b_if.req_write[i]          = 1'b0;
    b_if.req_addr[i*16 +: 16]  = addr;
    b_if.req_byteen[i*4 +: 4]  = 4'hF;
    b_if.req_wdata[i*32 +: 32] = '0;
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    step();
    HRESET = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      drive_a(i, 1'b0, 1'b0, '0, '0, '0);
      drive_b(i, 1'b0, '0);
    end
`ifdef SRAM_ARB_LOCK_EN
    a_if.req_lock = '0;
    b_if.req_lock = '0;
`endif
    step();
    step();
    check("rst_ren", 32'(a_if.mem_ren), 32'd0);
    check("rst_wen", 32'(a_if.mem_wen), 32'd0);
    check("rst_addr", 32'(a_if.mem_addr), 32'd0);
    check("rst_byteen", 32'(a_if.mem_byteen), 32'd0);
    check("rst_wdata", a_if.mem_wdata, 32'd0);
    check("rst_rspv", 32'(a_if.rsp_valid), 32'd0);
    check("rst_rdata", a_if.rsp_rdata, 32'd0);
    check("rst_ready", 32'(a_if.req_ready), 32'd0);
    HRESET = 1'b0;
    step();

    // Single read, RD_LATENCY=1.
    drive_a(0, 1'b1, 1'b0, 16'h0010, 4'hF, '0);
    #1 check("t1_ready", 32'(a_if.req_ready), 32'd1);
    step();
    drive_a(0, 1'b0, 1'b0, 16'h0010, 4'hF, '0);
    check("t1_ren", 32'(a_if.mem_ren), 32'd1);
    check("t1_wen", 32'(a_if.mem_wen), 32'd0);
    check("t1_addr", 32'(a_if.mem_addr), 32'h10);
    step();
    check("t1_ren_off", 32'(a_if.mem_ren), 32'd0);
    check("t1_rspv_early", 32'(a_if.rsp_valid), 32'd0);
    step();
    check("t1_rspv", 32'(a_if.rsp_valid), 32'd1);
    check("t1_rdata", a_if.rsp_rdata, 32'hDEADBEEF);
    step();
    check("t1_rspv_off", 32'(a_if.rsp_valid), 32'd0);
    check("t1_rdata_hold", a_if.rsp_rdata, 32'hDEADBEEF);

    // Both requesters valid: grants alternate starting at 0.
    do_reset();
    drive_a(0, 1'b1, 1'b0, 16'h0030, 4'hF, '0);
    drive_a(1, 1'b1, 1'b0, 16'h0031, 4'hF, '0);
    for (int k = 0; k < 6; k++) begin
      #1 check($sformatf("t2_ready%0d", k), 32'(a_if.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      check($sformatf("t2_ren%0d", k), 32'(a_if.mem_ren), 32'd1);
      check($sformatf("t2_addr%0d", k), 32'(a_if.mem_addr), (k % 2 == 0) ? 32'h30 : 32'h31);
    end
    drive_a(0, 1'b0, 1'b0, '0, '0, '0);
    drive_a(1, 1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 4; k++) step();

    // Write from 1 then read-after-write from 0.
    drive_a(1, 1'b1, 1'b1, 16'h0020, 4'b0011, 32'h12345678);
    #1 check("t3_ready_w", 32'(a_if.req_ready), 32'd2);
    step();
    drive_a(1, 1'b0, 1'b0, '0, '0, '0);
    drive_a(0, 1'b1, 1'b0, 16'h0020, 4'hF, '0);
    check("t3_wen", 32'(a_if.mem_wen), 32'd1);
    check("t3_ren_w", 32'(a_if.mem_ren), 32'd0);
    check("t3_byteen", 32'(a_if.mem_byteen), 32'h3);
    check("t3_wdata", a_if.mem_wdata, 32'h12345678);
    check("t3_waddr", 32'(a_if.mem_addr), 32'h20);
    #1 check("t3_ready_r", 32'(a_if.req_ready), 32'd1);
    step();
    drive_a(0, 1'b0, 1'b0, '0, '0, '0);
    check("t3_ren", 32'(a_if.mem_ren), 32'd1);
    check("t3_wen_r", 32'(a_if.mem_wen), 32'd0);
    step();
    check("t3_no_wrsp", 32'(a_if.rsp_valid), 32'd0);
    step();
    check("t3_rspv", 32'(a_if.rsp_valid), 32'd1);
    check("t3_rdata", a_if.rsp_rdata, 32'hAABB5678);
    step();

    // RD_LATENCY=2, interleaved reads r0@40, r1@41, r0@42.
    do_reset();
    drive_b(0, 1'b1, 16'h0040);
    drive_b(1, 1'b1, 16'h0041);
    #1 check("t4_ready0", 32'(b_if.req_ready), 32'd1);
    step();
    drive_b(0, 1'b1, 16'h0042);
    #1 check("t4_ready1", 32'(b_if.req_ready), 32'd2);
    step();
    drive_b(1, 1'b0, '0);
    #1 check("t4_ready2", 32'(b_if.req_ready), 32'd1);
    step();
    drive_b(0, 1'b0, '0);
    check("t4_rspv_c3", 32'(b_if.rsp_valid), 32'd0);
    step();
    check("t4_rspv_a", 32'(b_if.rsp_valid), 32'd1);
    check("t4_rdata_a", b_if.rsp_rdata, 32'h11110040);
    step();
    check("t4_rspv_b", 32'(b_if.rsp_valid), 32'd2);
    check("t4_rdata_b", b_if.rsp_rdata, 32'h11110041);
    step();
    check("t4_rspv_c", 32'(b_if.rsp_valid), 32'd1);
    check("t4_rdata_c", b_if.rsp_rdata, 32'h11110042);
    step();
    check("t4_rspv_end", 32'(b_if.rsp_valid), 32'd0);

    // Reset with two reads in flight; pointer would otherwise sit at 1.
    do_reset();
    drive_a(0, 1'b1, 1'b0, 16'h0010, 4'hF, '0);
    step();
    drive_a(0, 1'b1, 1'b0, 16'h0020, 4'hF, '0);
    step();
    drive_a(0, 1'b0, 1'b0, '0, '0, '0);
    HRESET = 1'b1;
    #1;
    check("t5_ren_drop", 32'(a_if.mem_ren), 32'd0);
    check("t5_addr_clr", 32'(a_if.mem_addr), 32'd0);
    check("t5_rspv_rst", 32'(a_if.rsp_valid), 32'd0);
    step();
    HRESET = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t5_no_rsp%0d", k), 32'(a_if.rsp_valid), 32'd0);
      check($sformatf("t5_rdata%0d", k), a_if.rsp_rdata, 32'd0);
    end
    drive_a(0, 1'b1, 1'b0, 16'h0001, 4'hF, '0);
    drive_a(1, 1'b1, 1'b0, 16'h0002, 4'hF, '0);
    #1 check("t5_first_gnt", 32'(a_if.req_ready), 32'd1);
    step();
    drive_a(0, 1'b0, 1'b0, '0, '0, '0);
    drive_a(1, 1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 4; k++) step();

`ifdef SRAM_ARB_LOCK_EN
    // Requester 1 holds the grant for three requests while 0 waits.
    do_reset();
    drive_a(1, 1'b1, 1'b0, 16'h0050, 4'hF, '0);
    a_if.req_lock[1] = 1'b1;
    #1 check("t6_lock0", 32'(a_if.req_ready), 32'd2);
    step();
    drive_a(0, 1'b1, 1'b0, 16'h0060, 4'hF, '0);
    #1 check("t6_lock1", 32'(a_if.req_ready), 32'd2);
    step();
    #1 check("t6_lock2", 32'(a_if.req_ready), 32'd2);
    step();
    drive_a(1, 1'b0, 1'b0, '0, '0, '0);
    a_if.req_lock[1] = 1'b0;
    #1 check("t6_release", 32'(a_if.req_ready), 32'd1);
    step();
    drive_a(0, 1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 4; k++) step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
